// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared definitions for the multiply/divide unit controller.
//   - WIDTH_INSTR and the decoded instruction symbols seen in the E stage
//   - FSM state type for the HI/LO sequencer
//   - helpers that classify an instruction symbol
package mdu_ctrl_pkg;

    localparam int WIDTH_INSTR = 5;

    localparam logic [WIDTH_INSTR-1:0] I_NOP   = 5'd0;
    localparam logic [WIDTH_INSTR-1:0] I_MULT  = 5'd1;
    localparam logic [WIDTH_INSTR-1:0] I_MULTU = 5'd2;
    localparam logic [WIDTH_INSTR-1:0] I_DIV   = 5'd3;
    localparam logic [WIDTH_INSTR-1:0] I_DIVU  = 5'd4;
    localparam logic [WIDTH_INSTR-1:0] I_MADD  = 5'd5;
    localparam logic [WIDTH_INSTR-1:0] I_MADDU = 5'd6;
    localparam logic [WIDTH_INSTR-1:0] I_MSUB  = 5'd7;
    localparam logic [WIDTH_INSTR-1:0] I_MSUBU = 5'd8;
    localparam logic [WIDTH_INSTR-1:0] I_MTHI  = 5'd9;
    localparam logic [WIDTH_INSTR-1:0] I_MTLO  = 5'd10;
    localparam logic [WIDTH_INSTR-1:0] I_MFHI  = 5'd11;
    localparam logic [WIDTH_INSTR-1:0] I_MFLO  = 5'd12;
    localparam logic [WIDTH_INSTR-1:0] I_ADD   = 5'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    function automatic logic is_mul_class(input logic [WIDTH_INSTR-1:0] op);
        return (op == I_MULT) || (op == I_MULTU) || (op == I_MADD) ||
               (op == I_MADDU) || (op == I_MSUB) || (op == I_MSUBU);
    endfunction

    function automatic logic is_div_class(input logic [WIDTH_INSTR-1:0] op);
        return (op == I_DIV) || (op == I_DIVU);
    endfunction

    function automatic logic is_md(input logic [WIDTH_INSTR-1:0] op);
        return is_mul_class(op) || is_div_class(op) ||
               (op == I_MTHI) || (op == I_MTLO) || (op == I_MFHI) || (op == I_MFLO);
    endfunction

endpackage

// File: rtl/mdu_ctrl_arith.sv
// mdu_arith: combinational datapath for the multiply/divide unit.
//   i_op      decoded instruction symbol
//   i_opA/B   rs / rt operands
//   i_hi/lo   current architectural HI/LO (accumulator for MADD/MSUB)
//   o_result  {hi,lo} value to commit when the operation completes
//   o_div0    divisor is zero (division must leave HI/LO untouched)
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [WIDTH_INSTR-1:0] i_op,
    input  logic [31:0]            i_opA,
    input  logic [31:0]            i_opB,
    input  logic [31:0]            i_hi,
    input  logic [31:0]            i_lo,
    output logic [63:0]            o_result,
    output logic                   o_div0
);

    logic [63:0] w_acc;
    logic [63:0] w_sa;
    logic [63:0] w_sb;
    logic [63:0] w_smul;
    logic [63:0] w_umul;

    assign w_acc = {i_hi, i_lo};

    // A 64x64 multiply of sign-extended operands, truncated to 64 bits,
    // is the exact two's-complement 32x32 signed product.
    assign w_sa   = {{32{i_opA[31]}}, i_opA};
    assign w_sb   = {{32{i_opB[31]}}, i_opB};
    assign w_smul = w_sa * w_sb;
    assign w_umul = {32'd0, i_opA} * {32'd0, i_opB};

    // Division on magnitudes with sign fix-up. This keeps one unsigned
    // divider and gives 0x80000000 / -1 = 0x80000000 rem 0 naturally.
    logic        w_sgn;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_den;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_sgn   = (i_op == I_DIV);
    assign w_neg_a = w_sgn & i_opA[31];
    assign w_neg_b = w_sgn & i_opB[31];
    assign w_mag_a = w_neg_a ? (~i_opA + 32'd1) : i_opA;
    assign w_mag_b = w_neg_b ? (~i_opB + 32'd1) : i_opB;
    // Substitute 1 for a zero divisor so the divider never sees X; the
    // result is discarded via o_div0.
    assign w_den   = (i_opB == 32'd0) ? 32'd1 : w_mag_b;
    assign w_uq    = w_mag_a / w_den;
    assign w_ur    = w_mag_a % w_den;
    assign w_quo   = (w_neg_a ^ w_neg_b) ? (~w_uq + 32'd1) : w_uq;
    assign w_rem   = w_neg_a ? (~w_ur + 32'd1) : w_ur;

    assign o_div0  = (i_opB == 32'd0);

    always_comb begin
        o_result = w_acc;
        case (i_op)
            I_MULT:  o_result = w_smul;
            I_MULTU: o_result = w_umul;
            I_MADD:  o_result = w_acc + w_smul;
            I_MADDU: o_result = w_acc + w_umul;
            I_MSUB:  o_result = w_acc - w_smul;
            I_MSUBU: o_result = w_acc - w_umul;
            I_DIV,
            I_DIVU:  o_result = o_div0 ? w_acc : {w_rem, w_quo};
            default: o_result = w_acc;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: execute-stage multiply/divide controller owning HI/LO.
//   clk, reset      clock; asynchronous active-high reset
//   instr, valid    decoded E-stage instruction and its valid bit
//   cancel          E-stage instruction flushed this cycle
//   opA, opB        forwarded rs / rt
//   busy            multi-cycle operation in flight
//   stall           hold the E-stage MD instruction (and younger)
//   rdata           MFHI/MFLO read data, else 0
//   hi, lo          architectural HI / LO
// The result is computed when the operation starts and parked in a pending
// register; the FSM only counts down and commits it, so a later flush of
// the issuing instruction cannot abort an operation already running.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH_INSTR-1:0] instr,
    input  logic                   valid,
    input  logic                   cancel,
    input  logic [31:0]            opA,
    input  logic [31:0]            opB,
    output logic                   busy,
    output logic                   stall,
    output logic [31:0]            rdata,
    output logic [31:0]            hi,
    output logic [31:0]            lo
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    mdu_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [63:0]      r_pending;
    logic             r_div0;

    logic             w_busy;
    logic             w_go;
    logic [63:0]      w_result;
    logic             w_div0;

    mdu_arith u_arith (
        .i_op     (instr),
        .i_opA    (opA),
        .i_opB    (opB),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .o_result (w_result),
        .o_div0   (w_div0)
    );

    assign w_busy = (r_state != ST_IDLE);
    assign w_go   = valid & ~cancel & ~w_busy;

    assign busy  = w_busy;
    assign hi    = r_hi;
    assign lo    = r_lo;
    // A flushed instruction is about to leave the pipe; holding it would
    // only delay the flush, so cancel also suppresses the stall.
    assign stall = valid & ~cancel & is_md(instr) & w_busy;

    always_comb begin
        rdata = 32'd0;
        if (instr == I_MFHI)      rdata = r_hi;
        else if (instr == I_MFLO) rdata = r_lo;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pending <= 64'd0;
            r_div0    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        if (is_mul_class(instr)) begin
                            r_state   <= ST_MUL;
                            r_cnt     <= MUL_LOAD;
                            r_pending <= w_result;
                            r_div0    <= 1'b0;
                        end else if (is_div_class(instr)) begin
                            r_state   <= ST_DIV;
                            r_cnt     <= DIV_LOAD;
                            r_pending <= w_result;
                            r_div0    <= w_div0;
                        end else if (instr == I_MTHI) begin
                            r_hi <= opA;
                        end else if (instr == I_MTLO) begin
                            r_lo <= opA;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (r_cnt == '0) begin
                        // Divide by zero still spends the full latency but
                        // leaves HI/LO alone.
                        if (!r_div0) begin
                            r_hi <= r_pending[63:32];
                            r_lo <= r_pending[31:0];
                        end
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
